// File: rtl/input_conditioner_pkg.sv
// Shared constants and helpers for the input pin conditioner.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package input_conditioner_pkg;

  // Default number of consecutive synchronized cycles a new level must persist.
  localparam int DEBOUNCE_CYCLES_DEF = 255;
  // Default number of pins conditioned in parallel.
  localparam int WIDTH_DEF = 8;

  // Classification of what a debouncer did on a given edge.
  typedef enum logic [1:0] {
    EDGE_NONE = 2'd0,
    EDGE_RISE = 2'd1,
    EDGE_FALL = 2'd2
  } edge_e;

  // Ceiling log2, used to size the per-bit debounce counters.
  // The loop is bounded so the function elaborates cleanly in synthesis.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage : input_conditioner_pkg

// File: rtl/input_conditioner_debounce_bit.sv
// Per-bit debouncer: counts how long the synchronized level differs from the accepted level.
// Latency: accepted level and pulse update DEBOUNCE_CYCLES edges after the synchronized level changes.
// Backpressure: none; ena_i=0 freezes the count and the accepted level and clears the pulses.
module debounce_bit
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ena_i,
  input  logic sync_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o,
  output logic change_d_o
);

  // The counter must be able to hold DEBOUNCE_CYCLES-1; sizing on DEBOUNCE_CYCLES+1
  // keeps at least one bit even when DEBOUNCE_CYCLES is 1.
  localparam int CNT_W = clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  edge_e            edge_d;

  // Next-state: hold everything while disabled, otherwise count toward acceptance.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    edge_d   = EDGE_NONE;
    if (ena_i) begin
      if (sync_i != stable_q) begin
        if (cnt_q == CNT_LAST) begin
          // New level has persisted long enough: accept it and restart the count.
          stable_d = sync_i;
          cnt_d    = '0;
          edge_d   = sync_i ? EDGE_RISE : EDGE_FALL;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        // Level agrees with the accepted one, so any partial glitch count is dropped.
        cnt_d = '0;
      end
    end
    rise_d     = (edge_d == EDGE_RISE);
    fall_d     = (edge_d == EDGE_FALL);
    change_d_o = rise_d | fall_d;
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;

endmodule : debounce_bit

// File: rtl/input_conditioner.sv
// Conditions the dedicated input pins: 2-flop synchronizer then per-bit debouncer with edge pulses.
// Latency: a held raw level appears on stable_out (with its pulse) DEBOUNCE_CYCLES+2 edges after first sampled.
// Backpressure: none; ena=0 freezes all state and forces the pulses and any_change low.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int WIDTH           = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] stable_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             any_change
);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] change_d;
  logic             any_change_q, any_change_d;

  // Synchronizer next-state: a plain two-stage shift that simply holds while disabled.
  always_comb begin
    sync1_d      = sync1_q;
    sync2_d      = sync2_q;
    any_change_d = 1'b0;
    if (ena) begin
      sync1_d      = raw_in;
      sync2_d      = sync1_q;
      any_change_d = |change_d;
    end
  end

  // Synchronizer and any_change registers; raw_in is ignored while in reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      any_change_q <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      any_change_q <= any_change_d;
    end
  end

  // One independent debouncer per pin.
  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce_bit (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .ena_i     (ena),
      .sync_i    (sync2_q[g]),
      .stable_o  (stable_out[g]),
      .rise_o    (rise_pulse[g]),
      .fall_o    (fall_pulse[g]),
      .change_d_o(change_d[g])
    );
  end

  assign any_change = any_change_q;

endmodule : input_conditioner

// File: tb/tb_input_conditioner.sv
// Directed, table-driven bench for input_conditioner with DEBOUNCE_CYCLES=4.
// Latency: n/a.
// Backpressure: n/a.
module tb_input_conditioner;

  localparam int DC = 4;
  localparam int W  = 8;

  logic         clk;
  logic         rst_n;
  logic         ena;
  logic [W-1:0] raw_in;
  logic [W-1:0] stable_out;
  logic [W-1:0] rise_pulse;
  logic [W-1:0] fall_pulse;
  logic         any_change;

  int checks;
  int errors;

  typedef struct {
    logic       r;
    logic       e;
    logic [7:0] raw;
    logic [7:0] st;
    logic [7:0] ri;
    logic [7:0] fa;
    logic       an;
  } vec_t;

  vec_t vecs[$];

  input_conditioner #(
    .DEBOUNCE_CYCLES(DC),
    .WIDTH          (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .raw_in    (raw_in),
    .stable_out(stable_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .any_change(any_change)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic e, input logic [7:0] raw,
                     input logic [7:0] st, input logic [7:0] ri, input logic [7:0] fa,
                     input logic an);
    vec_t v;
    v.r = r; v.e = e; v.raw = raw; v.st = st; v.ri = ri; v.fa = fa; v.an = an;
    vecs.push_back(v);
  endtask

  // Drive inputs, take one edge, sample 1 time unit later and compare every output.
  task automatic step(input logic r, input logic e, input logic [7:0] raw,
                      input logic [7:0] st, input logic [7:0] ri, input logic [7:0] fa,
                      input logic an, input string tag);
    rst_n  = r;
    ena    = e;
    raw_in = raw;
    @(posedge clk);
    #1;
    chk({tag, ".stable"}, stable_out, st);
    chk({tag, ".rise"}, rise_pulse, ri);
    chk({tag, ".fall"}, fall_pulse, fa);
    chk({tag, ".any"}, {7'd0, any_change}, {7'd0, an});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    ena    = 1'b1;
    raw_in = 8'hFF;

    // Reset with all pins high: everything stays clear.
    repeat (3) add(1'b0, 1'b1, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0);
    repeat (2) add(1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    // 3-cycle glitch on bit 3 is shorter than DC and must be rejected.
    repeat (3) add(1'b1, 1'b1, 8'h08, 8'h00, 8'h00, 8'h00, 1'b0);
    repeat (6) add(1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    // Bit 0 rises: accepted on edge DC+2 = 6, pulse for exactly one cycle.
    repeat (5) add(1'b1, 1'b1, 8'h01, 8'h00, 8'h00, 8'h00, 1'b0);
    add(1'b1, 1'b1, 8'h01, 8'h01, 8'h01, 8'h00, 1'b1);
    add(1'b1, 1'b1, 8'h01, 8'h01, 8'h00, 8'h00, 1'b0);
    // Bits 1..3 rise together.
    repeat (5) add(1'b1, 1'b1, 8'h0F, 8'h01, 8'h00, 8'h00, 1'b0);
    add(1'b1, 1'b1, 8'h0F, 8'h0F, 8'h0E, 8'h00, 1'b1);
    add(1'b1, 1'b1, 8'h0F, 8'h0F, 8'h00, 8'h00, 1'b0);
    // 0F -> F0: simultaneous rise and fall pulses on disjoint bits.
    repeat (5) add(1'b1, 1'b1, 8'hF0, 8'h0F, 8'h00, 8'h00, 1'b0);
    add(1'b1, 1'b1, 8'hF0, 8'hF0, 8'hF0, 8'h0F, 1'b1);
    add(1'b1, 1'b1, 8'hF0, 8'hF0, 8'h00, 8'h00, 1'b0);

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].e, vecs[i].raw, vecs[i].st, vecs[i].ri, vecs[i].fa,
           vecs[i].an, $sformatf("vec%0d", i));
    end

    // Enable freeze: bit 1 rises, ena=0 on edges 4..13 delays the flip from edge 6 to 16.
    repeat (2) step(1'b0, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, "frz_rst");
    for (int k = 1; k <= 18; k++) begin
      logic       e;
      logic [7:0] st;
      logic [7:0] ri;
      e  = !((k >= 4 && k <= 13) || k == 17);
      st = (k >= 16) ? 8'h02 : 8'h00;
      ri = (k == 16) ? 8'h02 : 8'h00;
      step(1'b1, e, 8'h02, st, ri, 8'h00, (k == 16), $sformatf("frz_e%0d", k));
    end

    // Reset mid-count: count is discarded, the rise restarts from scratch afterwards.
    repeat (2) step(1'b0, 1'b1, 8'h80, 8'h00, 8'h00, 8'h00, 1'b0, "mid_rst0");
    for (int k = 1; k <= 3; k++) begin
      step(1'b1, 1'b1, 8'h80, 8'h00, 8'h00, 8'h00, 1'b0, $sformatf("mid_pre%0d", k));
    end
    step(1'b0, 1'b1, 8'h80, 8'h00, 8'h00, 8'h00, 1'b0, "mid_rst");
    for (int k = 1; k <= DC + 3; k++) begin
      logic [7:0] st;
      logic [7:0] ri;
      st = (k >= DC + 2) ? 8'h80 : 8'h00;
      ri = (k == DC + 2) ? 8'h80 : 8'h00;
      step(1'b1, 1'b1, 8'h80, st, ri, 8'h00, (k == DC + 2), $sformatf("mid_e%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_input_conditioner

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Conditions the 8 dedicated input pins before they reach the top-level output mapping.
- Per bit: 2-flop synchronizer, then a counter-based debouncer. Produces a clean level plus single-cycle rise and fall pulses.
- Sits directly upstream of the top-level pin logic. The top wrapper feeds ui_in into raw_in and consumes stable_out and the pulses.

Parameters:
- DEBOUNCE_CYCLES, 255: consecutive synchronized cycles a new level must persist before it is accepted; legal range 1..65535.
- WIDTH, 8: number of input bits conditioned in parallel.

Ports:
- clk  input  1  clock
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- ena  input  1  design enable; 0 freezes all state
- raw_in  input  WIDTH  asynchronous raw pin levels (ui_in)
- stable_out  output  WIDTH  debounced level per bit
- rise_pulse  output  WIDTH  1-cycle pulse when a stable_out bit goes 0->1
- fall_pulse  output  WIDTH  1-cycle pulse when a stable_out bit goes 1->0
- any_change  output  1  OR-reduction of rise_pulse|fall_pulse, registered with them

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-low on rst_n. All state updates on the rising clk edge.
- Reset (rst_n=0 at an edge):
  - sync1, sync2, stable_out, counters, rise_pulse, fall_pulse and any_change all clear to 0.
  - raw_in is ignored while in reset.
- Synchronizer: sync1<=raw_in; sync2<=sync1. There is no other logic between the two flops.
- Per-bit counter cnt, width = clog2(DEBOUNCE_CYCLES+1). Each enabled edge:
  - If sync2!=stable and cnt==DEBOUNCE_CYCLES-1: stable<=sync2, cnt<=0, and the matching rise/fall pulse is set to 1.
  - Else if sync2!=stable: cnt<=cnt+1, pulses 0.
  - Else (sync2==stable): cnt<=0, pulses 0. Any glitch shorter than DEBOUNCE_CYCLES restarts the count.
- Latency:
  - Number edges from the first edge that samples the new raw level as edge 1.
  - sync1 updates on edge 1 and sync2 on edge 2.
  - stable_out and the pulse update on edge DEBOUNCE_CYCLES+2.
  - With DEBOUNCE_CYCLES=1, stable_out follows raw_in 3 edges late.
- Pulses:
  - Registered, and asserted in the same cycle stable_out takes its new value.
  - High for exactly 1 cycle.
  - rise_pulse and fall_pulse are never both high for the same bit.
- any_change is registered alongside the pulses and is therefore coincident with them.
- Bits are fully independent: simultaneous changes on several bits produce simultaneous pulses.
- ena=0:
  - All flops (sync, cnt, stable) hold their value.
  - Pulses and any_change are forced to 0 on that edge.
  - On return to ena=1 the counts resume; they are not restarted.
- Counter never wraps: the compare at DEBOUNCE_CYCLES-1 always clears it first.
- Reset mid-count: the count is discarded.
  - stable_out is 0 after reset even if raw_in is held high.
  - Once rst_n returns to 1, a high raw_in rises again after DEBOUNCE_CYCLES+2 edges.

Decomposition:
- Package input_conditioner_pkg holds:
  - localparam function clog2.
  - Default constants DEBOUNCE_CYCLES_DEF=255 and WIDTH_DEF=8.
- One sub-module, debounce_bit: per-bit sync2 compare, counter, stable flop and pulse flops.
  - Instantiated WIDTH times in a generate loop.
  - The shared two-flop synchronizer and the any_change reduction stay in the parent.

Test Plan:
- Reset: rst_n=0 for 3 edges with raw_in=8'hFF -> stable_out=8'h00, all pulses 0, any_change=0.
- Latency (DEBOUNCE_CYCLES=4): raw_in 8'h00->8'h01 held.
  - stable_out[0]=1 after edge 6.
  - rise_pulse=8'h01 and any_change=1 for exactly that cycle.
- Glitch rejection (DEBOUNCE_CYCLES=4): raw_in[3] high for 3 cycles then low -> stable_out stays 8'h00, no pulses.
- Simultaneous/independent: from 8'h0F stable, raw_in->8'hF0.
  - After DEBOUNCE_CYCLES+2 edges, rise_pulse=8'hF0 and fall_pulse=8'h0F in the same cycle.
  - stable_out=8'hF0.
- Enable freeze (DEBOUNCE_CYCLES=4): raw_in[1] rises, ena=0 for 10 cycles starting after edge 3.
  - Flip is delayed by exactly 10 edges.
  - No pulse appears while ena=0.
- Reset mid-count: raw_in=8'h80, rst_n=0 at edge 4 for 1 edge.
  - stable_out=8'h00 after reset.
  - stable_out[7]=1 exactly DEBOUNCE_CYCLES+2 edges after rst_n returns to 1.
